// File: rtl/game_round_timer.sv
// game_round_timer: GAME-state round countdown with pause, duck restart, optional auto-restart
// and registered HUD outputs (seconds left, warning, second tick, expiry pulse).
module game_round_timer #(
   parameter int         CLK_PER_MS   = 75000,
   parameter int         MS_PER_SEC   = 1000,
   parameter int         SEC_W        = 8,
   parameter logic [1:0] GAME_STATE   = 2'b10,
   parameter int         WARN_SEC     = 3,
   parameter bit         AUTO_RESTART = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       i_state_in,
   input  logic [SEC_W-1:0] i_time_in,
   input  logic             i_clicked_duck,
   input  logic             i_pause,
   output logic             o_end_of_time,
   output logic [SEC_W-1:0] o_time_left,
   output logic             o_warning,
   output logic             o_sec_tick,
   output logic             o_running
);
   localparam int CYC_W = $clog2(CLK_PER_MS);
   localparam int MS_W  = $clog2(MS_PER_SEC);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRE} state_t;

   state_t           r_state, w_state;
   logic [CYC_W-1:0] r_cyc, w_cyc;
   logic [MS_W-1:0]  r_ms, w_ms;
   logic [SEC_W-1:0] r_sec, w_sec, r_limit, w_limit, w_left;
   logic             w_game, w_cyc_wrap, w_sec_wrap, w_expire, w_eot, w_tick;

   assign w_game     = i_state_in == GAME_STATE;
   assign w_cyc_wrap = r_cyc == CYC_W'(CLK_PER_MS - 1);
   assign w_sec_wrap = w_cyc_wrap && r_ms == MS_W'(MS_PER_SEC - 1);
   assign w_expire   = w_sec_wrap && (r_sec + SEC_W'(1)) == r_limit;
   assign w_left     = (w_state == RUN || w_state == PAUSE) ? w_limit - w_sec : '0;

   always_comb begin
      w_state = r_state;
      w_cyc   = r_cyc;
      w_ms    = r_ms;
      w_sec   = r_sec;
      w_limit = r_limit;
      w_eot   = 1'b0;
      w_tick  = 1'b0;
      if (!w_game) begin
         w_state = IDLE;
         w_cyc   = '0;
         w_ms    = '0;
         w_sec   = '0;
         w_limit = '0;
      end else if (r_state == IDLE || (r_state == EXPIRE && AUTO_RESTART)) begin
         w_cyc   = '0;
         w_ms    = '0;
         w_sec   = '0;
         w_limit = i_time_in;
         w_eot   = i_time_in == '0;
         w_state = w_eot ? EXPIRE : RUN;
      end else if (r_state != EXPIRE) begin
         // a paused round only reaches its last second once pause drops without a click
         if (w_expire && (r_state == RUN || !(i_clicked_duck || i_pause))) begin
            w_state = EXPIRE;
            w_cyc   = '0;
            w_ms    = '0;
            w_sec   = '0;
            w_eot   = 1'b1;
            w_tick  = 1'b1;
         end else if (i_clicked_duck) begin
            w_cyc   = '0;
            w_ms    = '0;
            w_sec   = '0;
            w_limit = i_time_in;
         end else if (i_pause) begin
            w_state = PAUSE;
         end else begin
            w_state = RUN;
            w_cyc   = w_cyc_wrap ? '0 : r_cyc + CYC_W'(1);
            w_ms    = w_sec_wrap ? '0 : (w_cyc_wrap ? r_ms + MS_W'(1) : r_ms);
            w_sec   = w_sec_wrap ? r_sec + SEC_W'(1) : r_sec;
            w_tick  = w_sec_wrap;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_cyc         <= '0;
         r_ms          <= '0;
         r_sec         <= '0;
         r_limit       <= '0;
         o_end_of_time <= 1'b0;
         o_time_left   <= '0;
         o_warning     <= 1'b0;
         o_sec_tick    <= 1'b0;
         o_running     <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_cyc         <= w_cyc;
         r_ms          <= w_ms;
         r_sec         <= w_sec;
         r_limit       <= w_limit;
         o_end_of_time <= w_eot;
         o_time_left   <= w_left;
         o_warning     <= w_left != '0 && w_left <= SEC_W'(WARN_SEC);
         o_sec_tick    <= w_tick;
         o_running     <= w_state == RUN;
      end
   end
endmodule

// File: tb/tb_game_round_timer.sv
// tb_game_round_timer: vector table, directed round scenarios and random stimulus,
// checked against a model that counts elapsed round cycles (20 per second).
module tb_game_round_timer;
   localparam int SPS = 20;

   typedef struct {
      logic       rst;
      logic [1:0] st;
      logic [7:0] tin;
      logic       duck;
      logic       pau;
      int         n;
      logic       eot;
      logic       tick;
      logic [7:0] tl;
      logic       run;
      logic       warn;
   } vec_t;

   logic       clk = 1'b0, rst = 1'b0, duck = 1'b0, pau = 1'b0;
   logic [1:0] st = 2'b00;
   logic [7:0] tin = 8'd0;
   logic       d_eot[2], d_tick[2], d_run[2], d_warn[2];
   logic [7:0] d_tl[2];
   logic       e_eot[2], e_tick[2], e_run[2], e_warn[2];
   logic [7:0] e_tl[2];
   int         m_st[2] = '{0, 0}, m_lim[2] = '{0, 0}, m_el[2] = '{0, 0};
   int         n_chk = 0, n_fail = 0;
   int         ev0[$], ev1[$];
   int         tl0[0:199], run0[0:199];
   int         eot_k0;
   vec_t       vecs[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      game_round_timer #(
         .CLK_PER_MS(4), .MS_PER_SEC(5), .SEC_W(8), .GAME_STATE(2'b10),
         .WARN_SEC(2), .AUTO_RESTART(g == 1)
      ) u_dut (
         .clk(clk), .rst(rst), .i_state_in(st), .i_time_in(tin),
         .i_clicked_duck(duck), .i_pause(pau),
         .o_end_of_time(d_eot[g]), .o_time_left(d_tl[g]), .o_warning(d_warn[g]),
         .o_sec_tick(d_tick[g]), .o_running(d_run[g])
      );
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // model: idle=0, run=1, pause=2, expired=3; unit 1 auto-restarts
   task automatic model_step(input int u);
      e_eot[u]  = 1'b0;
      e_tick[u] = 1'b0;
      if (rst || st != 2'b10) begin
         m_st[u]  = 0;
         m_lim[u] = 0;
         m_el[u]  = 0;
      end else if (m_st[u] == 0 || (m_st[u] == 3 && u == 1)) begin
         m_lim[u] = int'(tin);
         m_el[u]  = 0;
         m_st[u]  = (tin == 8'd0) ? 3 : 1;
         e_eot[u] = tin == 8'd0;
      end else if (m_st[u] != 3) begin
         if (m_el[u] + 1 == m_lim[u] * SPS && (m_st[u] == 1 || !(duck || pau))) begin
            m_st[u]   = 3;
            m_el[u]   = 0;
            e_eot[u]  = 1'b1;
            e_tick[u] = 1'b1;
         end else if (duck) begin
            m_el[u]  = 0;
            m_lim[u] = int'(tin);
         end else if (pau) begin
            m_st[u] = 2;
         end else begin
            m_el[u]++;
            m_st[u]   = 1;
            e_tick[u] = (m_el[u] % SPS) == 0;
         end
      end
      e_run[u]  = m_st[u] == 1;
      e_tl[u]   = (m_st[u] == 1 || m_st[u] == 2) ? 8'(m_lim[u] - m_el[u] / SPS) : 8'd0;
      e_warn[u] = e_tl[u] != 8'd0 && e_tl[u] <= 8'd2;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("u%0d end_of_time", u), int'(d_eot[u]), int'(e_eot[u]));
         chk($sformatf("u%0d sec_tick", u), int'(d_tick[u]), int'(e_tick[u]));
         chk($sformatf("u%0d time_left", u), int'(d_tl[u]), int'(e_tl[u]));
         chk($sformatf("u%0d running", u), int'(d_run[u]), int'(e_run[u]));
         chk($sformatf("u%0d warning", u), int'(d_warn[u]), int'(e_warn[u]));
      end
   endtask

   // k counts edges after the round-entry edge (k=0)
   task automatic scenario(input int sc, input logic [7:0] t, input int n);
      ev0.delete();
      ev1.delete();
      rst  = 1'b1;
      st   = 2'b10;
      tin  = t;
      duck = 1'b0;
      pau  = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      eot_k0 = int'(d_eot[0]);
      for (int k = 1; k <= n; k++) begin
         duck = (sc == 1 && k == 30) || (sc == 3 && k == 60);
         pau  = sc == 2 && k >= 10 && k < 25;
         st   = (sc == 5 && k >= 25) ? 2'b01 : 2'b10;
         rst  = sc == 7 && k == 30;
         tick();
         if (d_eot[0]) ev0.push_back(k);
         if (d_eot[1]) ev1.push_back(k);
         tl0[k]  = int'(d_tl[0]);
         run0[k] = int'(d_run[0]);
      end
      duck = 1'b0;
      pau  = 1'b0;
      rst  = 1'b0;
   endtask

   function automatic int first(input int q[$]);
      return q.size() > 0 ? q[0] : -1;
   endfunction

   initial begin
      //               rst   st     tin   duck  pau   n   eot   tick  tl    run   warn
      vecs.push_back('{1'b1, 2'd0, 8'd0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd2, 8'd3, 1'b0, 1'b0,  1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 2'd2, 8'd3, 1'b0, 1'b0, 19, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 2'd2, 8'd3, 1'b0, 1'b0,  1, 1'b0, 1'b1, 8'd2, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 2'd2, 8'd3, 1'b0, 1'b0,  1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 2'd2, 8'd3, 1'b0, 1'b0, 19, 1'b0, 1'b1, 8'd1, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 2'd2, 8'd3, 1'b0, 1'b0, 19, 1'b0, 1'b0, 8'd1, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 2'd2, 8'd3, 1'b0, 1'b0,  1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd2, 8'd3, 1'b0, 1'b0,  1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd2, 8'd3, 1'b1, 1'b1, 30, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd1, 8'd3, 1'b0, 1'b0,  1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd2, 8'd0, 1'b0, 1'b0,  1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd2, 8'd0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd0, 8'd0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'd2, 8'd2, 1'b0, 1'b0,  1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 2'd2, 8'd7, 1'b0, 1'b0, 20, 1'b0, 1'b1, 8'd1, 1'b1, 1'b1});
      vecs.push_back('{1'b0, 2'd2, 8'd7, 1'b0, 1'b0, 20, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0});
      for (int i = 0; i < vecs.size(); i++) begin
         rst  = vecs[i].rst;
         st   = vecs[i].st;
         tin  = vecs[i].tin;
         duck = vecs[i].duck;
         pau  = vecs[i].pau;
         repeat (vecs[i].n) tick();
         chk($sformatf("vec%0d end_of_time", i), int'(d_eot[0]), int'(vecs[i].eot));
         chk($sformatf("vec%0d sec_tick", i), int'(d_tick[0]), int'(vecs[i].tick));
         chk($sformatf("vec%0d time_left", i), int'(d_tl[0]), int'(vecs[i].tl));
         chk($sformatf("vec%0d running", i), int'(d_run[0]), int'(vecs[i].run));
         chk($sformatf("vec%0d warning", i), int'(d_warn[0]), int'(vecs[i].warn));
      end
      duck = 1'b0;
      pau  = 1'b0;

      scenario(1, 8'd3, 100);
      chk("duck pulse count", ev0.size(), 1);
      chk("duck pulse cycle", first(ev0), 90);
      chk("duck time_left after click", tl0[30], 3);

      scenario(2, 8'd3, 100);
      chk("pause pulse cycle", first(ev0), 75);
      chk("pause running", run0[15], 0);
      chk("pause time_left frozen", tl0[24], 3);
      chk("pause resumed running", run0[25], 1);

      scenario(3, 8'd3, 100);
      chk("collision pulse count", ev0.size(), 1);
      chk("collision pulse cycle", first(ev0), 60);
      chk("collision held time_left", tl0[61], 0);
      chk("collision held running", run0[61], 0);

      scenario(4, 8'd1, 70);
      chk("noauto pulse count", ev0.size(), 1);
      chk("auto pulse count", ev1.size(), 3);
      chk("auto pulse 1", first(ev1), 20);
      chk("auto pulse 2", ev1.size() > 1 ? ev1[1] : -1, 41);
      chk("auto pulse 3", ev1.size() > 2 ? ev1[2] : -1, 62);

      scenario(5, 8'd3, 40);
      chk("abort pulse count", ev0.size(), 0);
      chk("abort time_left before", tl0[24], 2);
      chk("abort time_left", tl0[25], 0);
      chk("abort running", run0[25], 0);

      scenario(6, 8'd0, 10);
      chk("zero entry pulse", eot_k0, 1);
      chk("zero hold pulses", ev0.size(), 0);
      chk("zero auto pulses", ev1.size(), 10);

      scenario(7, 8'd3, 100);
      chk("rst time_left", tl0[30], 0);
      chk("rst running", run0[30], 0);
      chk("rst restart pulse", first(ev0), 91);

      for (int i = 0; i < 3000; i++) begin
         rst  = $urandom_range(0, 199) == 0;
         st   = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
         tin  = 8'($urandom_range(0, 3));
         duck = $urandom_range(0, 39) == 0;
         if (duck && tin == 8'd0) tin = 8'd1;
         if ($urandom_range(0, 9) == 0) pau = ~pau;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/game_round_timer.md
# game_round_timer

Parametrised round timer for the GAME state. It counts a configurable round length in seconds from a clock prescaler and signals expiry to the main control module with a one-cycle pulse. Beyond a plain timeout, it adds pause/resume, restart on duck hit, optional auto-restart, a remaining-seconds output for the HUD, and a low-time warning flag. It sits between the main state machine (state_in, end_of_time) and the display/overlay logic (time_left, warning, sec_tick).

## Interface
- CLK_PER_MS, default 75000: clock cycles per millisecond (≥2).
- MS_PER_SEC, default 1000: milliseconds per second (≥2; reduced in simulation).
- SEC_W, default 8: width of round-length and remaining-time values.
- GAME_STATE, default 2'b10: state_in encoding that enables the timer.
- WARN_SEC, default 3: warning threshold in seconds.
- AUTO_RESTART, default 0: 1 = restart the round after expiry; 0 = hold expired.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- state_in  in  2  main FSM state.
- time_in  in  SEC_W  round length in seconds, latched at round start.
- clicked_duck  in  1  restart the round (level; sampled every cycle).
- pause  in  1  freeze counting while high.
- end_of_time  out  1  one-cycle expiry pulse.
- time_left  out  SEC_W  seconds remaining (limit − elapsed).
- warning  out  1  high while round active and 0 < time_left ≤ WARN_SEC.
- sec_tick  out  1  one-cycle pulse on every elapsed-second increment.
- running  out  1  high in RUN state only.

## Operation
- Internal counters: cyc_cnt (0..CLK_PER_MS−1), ms_cnt (0..MS_PER_SEC−1), sec_cnt (SEC_W bits), and limit (SEC_W bits, latched from time_in).
- FSM states: IDLE, RUN, PAUSE, EXPIRE. All counters are zero in IDLE.
- Any state with state_in ≠ GAME_STATE goes to IDLE on the next edge. All counters and outputs clear. This takes priority over everything except rst.
- IDLE with state_in == GAME_STATE: latch limit = time_in and zero the counters. If time_in == 0, go to EXPIRE and assert end_of_time; otherwise go to RUN.
- RUN, per cycle:
  - cyc_cnt increments.
  - At CLK_PER_MS−1, cyc_cnt wraps to 0 and ms_cnt increments.
  - When ms_cnt is at MS_PER_SEC−1 on that wrap, ms_cnt wraps to 0, sec_cnt increments, and sec_tick is asserted.
- Expiry: when sec_cnt increments to limit, go to EXPIRE, assert end_of_time, zero the counters, and set time_left = 0.
- Event priority within RUN: expiry > clicked_duck > pause > count.
  - Expiry and clicked_duck in the same cycle: expiry wins.
  - clicked_duck: zero the counters, re-latch limit = time_in, stay in RUN, no sec_tick.
  - pause (no click, no expiry): go to PAUSE, counters hold.
- PAUSE:
  - Counters and time_left hold.
  - pause low: go to RUN.
  - clicked_duck: zero the counters, re-latch limit, stay in PAUSE.
- EXPIRE:
  - AUTO_RESTART=1: next edge re-latches limit, zeroes counters, and enters RUN (or EXPIRE again if time_in == 0).
  - AUTO_RESTART=0: hold until state_in leaves GAME_STATE. clicked_duck and pause are ignored.
- time_left = limit − sec_cnt, registered. Never wraps, since sec_cnt ≤ limit by construction. Reads 0 in IDLE and EXPIRE.
- time_in changes mid-round are ignored until the next latch.

## Timing
- All outputs are registered and update on the same edge as the state change. There is no combinational path from inputs to outputs.
- Reset values: end_of_time=0, time_left=0, warning=0, sec_tick=0, running=0, FSM=IDLE, all counters 0.
- Round length: exactly limit·MS_PER_SEC·CLK_PER_MS cycles, measured from the edge entering RUN (or the restart edge) to the edge asserting end_of_time.
- end_of_time: high for exactly one cycle per expiry. Its edge coincides with the final sec_tick, so sec_tick is also high that cycle.
- Pause latency: counting stops on the edge that samples pause=1 and resumes on the edge that samples pause=0. Paused cycles do not count.
- rst mid-round: the next edge forces reset values. No end_of_time is issued.

## Test plan
Bench parameters: CLK_PER_MS=4, MS_PER_SEC=5 (20 cycles per second), SEC_W=8, WARN_SEC=2.

- **Basic round:** rst, then state_in=2'b10, time_in=3.
  - Expect running=1 the cycle after entry.
  - Expect sec_tick at +20 and +40 cycles.
  - Expect end_of_time plus sec_tick exactly 60 cycles after RUN entry, time_left 3→2→1→0, and warning high once time_left ≤ 2.
- **Duck restart:** time_in=3, clicked_duck pulsed at cycle 30.
  - Expect time_left back to 3 and end_of_time at cycle 30+60.
  - Expect no pulse at cycle 60.
- **Pause:** pause high for 15 cycles starting at cycle 10.
  - Expect time_left frozen and running=0 during the pause.
  - Expect end_of_time at cycle 75.
- **Collision:** clicked_duck asserted on the cycle the final second elapses. Expect end_of_time=1, with no restart.
- **Modes:**
  - AUTO_RESTART=0: expect a single pulse, then time_left=0 held while in GAME.
  - AUTO_RESTART=1, time_in=1: expect pulses every 21 cycles (20 plus the restart edge).
- **Abort and edge cases:**
  - state_in changes to 2'b01 at cycle 25: all outputs 0 the next cycle, no pulse.
  - time_in=0: end_of_time on the entry edge.
  - rst at cycle 30: reset values on the next cycle.
